// File: rtl/progc_pkg.sv
// Shared types and constants for the program-counter generator.
package progc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_BR   = 2'd0,
        SEL_JAL  = 2'd1,
        SEL_JALR = 2'd2
    } tgt_sel_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_tgt.sv
// Redirect target adder: pc-relative for branch/jal, register-relative for jalr.
module pc_tgt
    import progc_pkg::*;
#(
    parameter int n = 32
) (
    input  logic        [n-1:0] pcOut,
    input  logic        [n-1:0] rs1,
    input  logic signed [n-1:0] imm,
    input  tgt_sel_t            sel,
    output logic        [n-1:0] target,
    output logic                misaligned
);

    logic signed [n-1:0] base;
    logic signed [n-1:0] sum;

    always_comb begin
        base = (sel == SEL_JALR) ? signed'(rs1) : signed'(pcOut);
        sum  = base + imm;
        // jalr drops bit 0 of the computed address; other targets pass through
        if (sel == SEL_JALR) begin
            target = {sum[n-1:1], 1'b0};
        end else begin
            target = sum;
        end
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/TRAP sequencing, stall-aware increment,
// prioritised redirects and misaligned-target trapping.
module pc_gen
    import progc_pkg::*;
#(
    parameter int           n         = 32,
    parameter logic [n-1:0] RESET_VEC = '0,
    parameter logic [n-1:0] TRAP_VEC  = n'('h40)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         incr,
    input  logic         brnch,
    input  logic         jmp,
    input  logic         jmplr,
    input  logic [n-1:0] imm,
    input  logic [n-1:0] rs1,
    input  logic         fetchRdy,
    input  logic         trapClr,
    output logic [n-1:0] pcOut,
    output logic         pcValid,
    output logic [n-1:0] pcPlus4,
    output logic         misalign,
    output logic [n-1:0] badAddr
);

    pc_state_t   state;
    tgt_sel_t    sel;
    logic        redirect;
    logic [n-1:0] target;
    logic        tgt_mis;

    always_comb begin
        sel = SEL_BR;
        if (jmplr) begin
            sel = SEL_JALR;
        end else if (jmp) begin
            sel = SEL_JAL;
        end
        redirect = jmplr | jmp | brnch;
    end

    pc_tgt #(.n(n)) u_tgt (
        .pcOut      (pcOut),
        .rs1        (rs1),
        .imm        (imm),
        .sel        (sel),
        .target     (target),
        .misaligned (tgt_mis)
    );

    assign pcPlus4 = pcOut + n'(PC_INC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pcOut    <= RESET_VEC;
            badAddr  <= '0;
            pcValid  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    pcValid <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        // a target off a word boundary never reaches pcOut
                        if (tgt_mis) begin
                            state    <= TRAP;
                            badAddr  <= target;
                            pcValid  <= 1'b0;
                            misalign <= 1'b1;
                        end else begin
                            pcOut <= target;
                        end
                    end else if (incr && fetchRdy) begin
                        pcOut <= pcPlus4;
                    end
                end
                TRAP: begin
                    if (trapClr) begin
                        state    <= RUN;
                        pcOut    <= TRAP_VEC;
                        pcValid  <= 1'b1;
                        misalign <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pcValid  <= 1'b0;
                    misalign <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: n, 32, address width in bits; legal range 8..64.
REQ-002 Parameter: RESET_VEC, 0, PC value loaded on reset.
REQ-003 Parameter: TRAP_VEC, 'h40, PC value loaded when a trap is cleared.
REQ-004 Port: clock  input  1  single system clock; all state updates on posedge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: incr  input  1  sequential advance request (PC+4).
REQ-007 Port: brnch  input  1  conditional branch taken; target = pcOut + imm.
REQ-008 Port: jmp  input  1  jal; target = pcOut + imm.
REQ-009 Port: jmplr  input  1  jalr; target = (rs1 + imm) with bit 0 cleared.
REQ-010 Port: imm  input  n  sign-extended immediate offset.
REQ-011 Port: rs1  input  n  jalr base register value.
REQ-012 Port: fetchRdy  input  1  fetch side accepts the current pcOut.
REQ-013 Port: trapClr  input  1  leave TRAP state and restart at TRAP_VEC.
REQ-014 Port: pcOut  output  n  current program counter (byte address).
REQ-015 Port: pcValid  output  1  pcOut is valid for fetch.
REQ-016 Port: pcPlus4  output  n  pcOut + 4, link value for jal/jalr.
REQ-017 Port: misalign  output  1  high while in TRAP state.
REQ-018 Port: badAddr  output  n  offending target captured on trap entry.

Function
REQ-019 The block SHALL implement a three-state FSM: BOOT, RUN, TRAP.
REQ-020 BOOT SHALL last exactly one cycle after reset deassertion, with pcValid=0, then go to RUN with pcOut unchanged.
REQ-021 In RUN, pcValid SHALL be 1; in BOOT and TRAP, pcValid SHALL be 0.
REQ-022 In RUN, redirect priority SHALL be jmplr > jmp > brnch > incr; lower-priority requests in the same cycle are ignored.
REQ-023 A redirect (jmplr/jmp/brnch) SHALL update pcOut on the next edge regardless of fetchRdy.
REQ-024 incr SHALL update pcOut to pcOut+4 only when fetchRdy=1; otherwise pcOut holds (stall).
REQ-025 With no request, pcOut SHALL hold.
REQ-026 All arithmetic SHALL be modulo 2^n; 2^n-4 incremented SHALL wrap to 0.
REQ-027 pcPlus4 SHALL be combinational from pcOut (zero cycle latency), also modulo 2^n.
REQ-028 A selected redirect target with bit 1 set SHALL NOT load pcOut; FSM enters TRAP, badAddr captures the target, pcOut holds.
REQ-029 In TRAP, all requests SHALL be ignored except trapClr; on trapClr, pcOut=TRAP_VEC, badAddr holds, FSM goes to RUN.
REQ-030 Requests in BOOT SHALL be ignored.
REQ-031 pcOut SHALL always be 4-byte aligned (bits [1:0]=0) provided RESET_VEC and TRAP_VEC are aligned.

Reset
REQ-032 On reset assertion, asynchronously: pcOut=RESET_VEC, FSM=BOOT, badAddr=0, pcValid=0, misalign=0.
REQ-033 Reset asserted mid-TRAP or mid-stall SHALL abandon that state with no residual effect.

Structure
REQ-034 FSM state enum (BOOT, RUN, TRAP) and the PC increment constant 4 SHALL reside in shared package progc_pkg.
REQ-035 Target selection and addition SHALL be a sub-module pc_tgt (combinational: inputs pcOut, rs1, imm, sel; outputs target, misaligned flag).

Verification
REQ-036 Reset then release, RESET_VEC=0: cycle 1 pcValid=0, pcOut=0; cycle 2 pcValid=1; incr+fetchRdy x3 -> pcOut=0xC.
REQ-037 pcOut=0x100, incr=1, fetchRdy=0 for 2 cycles -> pcOut stays 0x100; fetchRdy=1 -> 0x104.
REQ-038 pcOut=0x100, brnch=1, jmp=1, jmplr=1, rs1=0x2001, imm=0x10 -> pcOut=0x2010; pcPlus4 was 0x104 during request.
REQ-039 pcOut=0x100, brnch=1, imm=0x6 -> misalign=1, badAddr=0x106, pcOut=0x100, pcValid=0; trapClr -> pcOut=0x40, RUN.
REQ-040 n=8, pcOut=0xFC, incr+fetchRdy -> pcOut=0x00; imm=0xF8 (-8) brnch at 0x04 -> 0xFC.
REQ-041 Reset asserted asynchronously mid-TRAP -> immediately pcOut=RESET_VEC, misalign=0, badAddr=0.
